// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: opcodes, functs,
// ALU operations, FSM states, instruction classes and pc source codes.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4,
    ALU_LUI = 4'd5
  } aluop_t;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_RALU,
    C_IALU,
    C_LW,
    C_SW,
    C_BEQ,
    C_J,
    C_ILL
  } iclass_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and zero flag in,
// enables, selects and debug status out.
interface mc_ctrl_if
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
);

  logic [5:0]       op;
  logic [5:0]       funct;
  logic             zero;

  logic             pc_write;
  logic [1:0]       pc_src;
  logic             ir_write;
  logic             reg_write;
  logic             mem_read;
  logic             mem_write;
  logic             s_ext;
  logic             s_num_write;
  logic             s_b;
  logic             s_wb;
  aluop_t           aluop;
  state_t           state;
  logic             illegal;
  logic [CNT_W-1:0] icount;

  modport master (
    input  op, funct, zero,
    output pc_write, pc_src, ir_write, reg_write, mem_read, mem_write,
           s_ext, s_num_write, s_b, s_wb, aluop, state, illegal, icount
  );

  modport slave (
    output op, funct, zero,
    input  pc_write, pc_src, ir_write, reg_write, mem_read, mem_write,
           s_ext, s_num_write, s_b, s_wb, aluop, state, illegal, icount
  );

endinterface

// File: rtl/mc_decode.sv
// Combinational decoder: classifies op/funct and supplies the ALU-side selects
// (aluop, s_ext, s_b) that stay constant across the EX, MEM and WB steps.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output iclass_t    o_class,
  output aluop_t     o_aluop,
  output logic       o_s_ext,
  output logic       o_s_b
);

  always_comb begin
    o_class = C_ILL;
    o_aluop = ALU_ADD;
    o_s_ext = 1'b0;
    o_s_b   = 1'b0;
    case (i_op)
      OP_RTYPE: begin
        o_class = C_RALU;
        case (i_funct)
          FN_ADDU: o_aluop = ALU_ADD;
          FN_SUBU: o_aluop = ALU_SUB;
          FN_AND:  o_aluop = ALU_AND;
          FN_OR:   o_aluop = ALU_OR;
          FN_SLT:  o_aluop = ALU_SLT;
          default: o_class = C_ILL;
        endcase
      end
      OP_J: o_class = C_J;
      OP_BEQ: begin
        o_class = C_BEQ;
        o_aluop = ALU_SUB;
      end
      OP_ADDI, OP_ADDIU: begin
        o_class = C_IALU;
        o_s_ext = 1'b1;
        o_s_b   = 1'b1;
      end
      OP_ANDI: begin
        o_class = C_IALU;
        o_aluop = ALU_AND;
        o_s_b   = 1'b1;
      end
      OP_ORI: begin
        o_class = C_IALU;
        o_aluop = ALU_OR;
        o_s_b   = 1'b1;
      end
      OP_LUI: begin
        o_class = C_IALU;
        o_aluop = ALU_LUI;
        o_s_b   = 1'b1;
      end
      OP_LW: begin
        o_class = C_LW;
        o_s_ext = 1'b1;
        o_s_b   = 1'b1;
      end
      OP_SW: begin
        o_class = C_SW;
        o_s_ext = 1'b1;
        o_s_b   = 1'b1;
      end
      default: o_class = C_ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset datapath: sequences IF/ID/EX/MEM/WB,
// drives every enable and select, and counts retired instructions.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter bit TRAP_ILLEGAL = 1'b1,
  parameter int CNT_W        = 32
) (
  input logic       clock,
  input logic       reset,
  mc_ctrl_if.master bus
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_icount;
  logic             w_retire;
  iclass_t          w_class;
  aluop_t           w_aluop;
  logic             w_s_ext;
  logic             w_s_b;

  mc_decode u_decode (
    .i_op    (bus.op),
    .i_funct (bus.funct),
    .o_class (w_class),
    .o_aluop (w_aluop),
    .o_s_ext (w_s_ext),
    .o_s_b   (w_s_b)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IF;
      r_icount <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) begin
        r_icount <= r_icount + CNT_W'(1);
      end
    end
  end

  // ALU selects are held from EX through MEM/WB so the address and result paths stay stable.
  always_comb begin
    w_next          = r_state;
    w_retire        = 1'b0;
    bus.pc_write    = 1'b0;
    bus.pc_src      = PC_SEQ;
    bus.ir_write    = 1'b0;
    bus.reg_write   = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.s_ext       = 1'b0;
    bus.s_num_write = 1'b0;
    bus.s_b         = 1'b0;
    bus.s_wb        = 1'b0;
    bus.aluop       = ALU_ADD;
    bus.illegal     = 1'b0;
    if (!reset) begin
      unique case (r_state)
        S_IF: begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          w_next       = S_ID;
        end
        S_ID: begin
          if (w_class == C_J) begin
            bus.pc_write = 1'b1;
            bus.pc_src   = PC_JUMP;
            w_retire     = 1'b1;
            w_next       = S_IF;
          end else if (w_class == C_ILL) begin
            w_next = TRAP_ILLEGAL ? S_HALT : S_IF;
          end else begin
            w_next = S_EX;
          end
        end
        S_EX: begin
          bus.aluop = w_aluop;
          bus.s_ext = w_s_ext;
          bus.s_b   = w_s_b;
          unique case (w_class)
            C_BEQ: begin
              bus.pc_write = bus.zero;
              bus.pc_src   = PC_BRANCH;
              w_retire     = 1'b1;
              w_next       = S_IF;
            end
            C_LW, C_SW:     w_next = S_MEM;
            C_RALU, C_IALU: w_next = S_WB;
            default:        w_next = S_IF;
          endcase
        end
        S_MEM: begin
          bus.aluop = w_aluop;
          bus.s_ext = w_s_ext;
          bus.s_b   = w_s_b;
          if (w_class == C_LW) begin
            bus.mem_read = 1'b1;
            w_next       = S_WB;
          end else begin
            bus.mem_write = 1'b1;
            w_retire      = 1'b1;
            w_next        = S_IF;
          end
        end
        S_WB: begin
          bus.aluop       = w_aluop;
          bus.s_ext       = w_s_ext;
          bus.s_b         = w_s_b;
          bus.reg_write   = 1'b1;
          bus.s_num_write = (w_class == C_RALU);
          bus.s_wb        = (w_class == C_LW);
          w_retire        = 1'b1;
          w_next          = S_IF;
        end
        S_HALT: begin
          bus.illegal = 1'b1;
          w_next      = S_HALT;
        end
        default: w_next = S_IF;
      endcase
    end
  end

  assign bus.state  = r_state;
  assign bus.icount = r_icount;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: one trapping 32-bit-counter instance and one
// non-trapping 4-bit-counter instance share the same instruction stream.
module tb_mc_ctrl;

  typedef struct packed {
    logic [2:0]  state;
    logic        pcWrite;
    logic [1:0]  pcSrc;
    logic        irWrite;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        sExt;
    logic        sNumWrite;
    logic        sB;
    logic        sWb;
    logic [3:0]  aluop;
    logic        illegal;
    logic [31:0] icount;
  } obs_t;

  typedef struct {
    obs_t o;
    bit   chkAll;
    bit   chkState;
    bit   chkIcount;
  } exp_t;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_J = 5, K_ILL = 6;

  logic        clock  = 1'b0;
  logic        reset  = 1'b1;
  logic [5:0]  opR    = '0;
  logic [5:0]  functR = '0;
  logic        zeroR  = 1'b0;
  int          checks = 0;
  int          errors = 0;
  exp_t        qA[$];
  exp_t        qB[$];
  obs_t        steps[$];
  logic [31:0] cntA = '0;
  logic [3:0]  cntB = '0;
  obs_t        obsA;
  obs_t        obsB;
  exp_t        eA;
  exp_t        eB;
  logic [5:0]  legalOp[10];
  logic [5:0]  rFunct[5];

  always #5 clock = ~clock;

  mc_ctrl_if #(.CNT_W(32)) busA ();
  mc_ctrl_if #(.CNT_W(4))  busB ();

  assign busA.op    = opR;
  assign busA.funct = functR;
  assign busA.zero  = zeroR;
  assign busB.op    = opR;
  assign busB.funct = functR;
  assign busB.zero  = zeroR;

  mc_ctrl #(.TRAP_ILLEGAL(1'b1), .CNT_W(32)) dutA (
    .clock (clock),
    .reset (reset),
    .bus   (busA)
  );

  mc_ctrl #(.TRAP_ILLEGAL(1'b0), .CNT_W(4)) dutB (
    .clock (clock),
    .reset (reset),
    .bus   (busB)
  );

  always_comb begin
    obsA           = '0;
    obsA.state     = busA.state;
    obsA.pcWrite   = busA.pc_write;
    obsA.pcSrc     = busA.pc_src;
    obsA.irWrite   = busA.ir_write;
    obsA.regWrite  = busA.reg_write;
    obsA.memRead   = busA.mem_read;
    obsA.memWrite  = busA.mem_write;
    obsA.sExt      = busA.s_ext;
    obsA.sNumWrite = busA.s_num_write;
    obsA.sB        = busA.s_b;
    obsA.sWb       = busA.s_wb;
    obsA.aluop     = busA.aluop;
    obsA.illegal   = busA.illegal;
    obsA.icount    = busA.icount;
  end

  always_comb begin
    obsB           = '0;
    obsB.state     = busB.state;
    obsB.pcWrite   = busB.pc_write;
    obsB.pcSrc     = busB.pc_src;
    obsB.irWrite   = busB.ir_write;
    obsB.regWrite  = busB.reg_write;
    obsB.memRead   = busB.mem_read;
    obsB.memWrite  = busB.mem_write;
    obsB.sExt      = busB.s_ext;
    obsB.sNumWrite = busB.s_num_write;
    obsB.sB        = busB.s_b;
    obsB.sWb       = busB.s_wb;
    obsB.aluop     = busB.aluop;
    obsB.illegal   = busB.illegal;
    obsB.icount    = {28'd0, busB.icount};
  end

  // Instruction classification straight from the opcode/funct table.
  function automatic int kindOf(input logic [5:0] op, input logic [5:0] funct);
    case (op)
      6'h00:   return (funct == 6'h21 || funct == 6'h23 || funct == 6'h24 ||
                       funct == 6'h25 || funct == 6'h2A) ? K_R : K_ILL;
      6'h02:   return K_J;
      6'h04:   return K_BEQ;
      6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0F: return K_I;
      6'h23:   return K_LW;
      6'h2B:   return K_SW;
      default: return K_ILL;
    endcase
  endfunction

  function automatic void execSel(input logic [5:0] op, input logic [5:0] funct,
                                  output logic [3:0] alu, output logic se, output logic sb);
    alu = 4'd0; se = 1'b0; sb = 1'b0;
    case (op)
      6'h00: case (funct)
               6'h23:   alu = 4'd1;
               6'h24:   alu = 4'd2;
               6'h25:   alu = 4'd3;
               6'h2A:   alu = 4'd4;
               default: alu = 4'd0;
             endcase
      6'h08, 6'h09, 6'h23, 6'h2B: begin se = 1'b1; sb = 1'b1; end
      6'h0C: begin alu = 4'd2; sb = 1'b1; end
      6'h0D: begin alu = 4'd3; sb = 1'b1; end
      6'h0F: begin alu = 4'd5; sb = 1'b1; end
      6'h04: alu = 4'd1;
      default: ;
    endcase
  endfunction

  // Cycle-by-cycle expected outputs for one legal instruction.
  function automatic void buildSteps(input logic [5:0] op, input logic [5:0] funct, input logic zero);
    obs_t s;
    int k;
    logic [3:0] alu;
    logic se, sb;
    k = kindOf(op, funct);
    execSel(op, funct, alu, se, sb);
    steps.delete();
    s = '0; s.state = 3'd0; s.irWrite = 1'b1; s.pcWrite = 1'b1;
    steps.push_back(s);
    s = '0; s.state = 3'd1;
    if (k == K_J) begin
      s.pcWrite = 1'b1; s.pcSrc = 2'b10;
      steps.push_back(s);
      return;
    end
    steps.push_back(s);
    s = '0; s.state = 3'd2; s.aluop = alu; s.sExt = se; s.sB = sb;
    if (k == K_BEQ) begin
      s.pcWrite = zero; s.pcSrc = 2'b01;
      steps.push_back(s);
      return;
    end
    steps.push_back(s);
    if (k == K_LW || k == K_SW) begin
      s = '0; s.state = 3'd3; s.aluop = alu; s.sExt = se; s.sB = sb;
      s.memRead = (k == K_LW); s.memWrite = (k == K_SW);
      steps.push_back(s);
      if (k == K_SW) return;
    end
    s = '0; s.state = 3'd4; s.aluop = alu; s.sExt = se; s.sB = sb;
    s.regWrite = 1'b1; s.sNumWrite = (k == K_R); s.sWb = (k == K_LW);
    steps.push_back(s);
  endfunction

  function automatic void pushExp(input obs_t oA, input obs_t oB, input bit all,
                                  input bit st, input bit ic);
    exp_t e;
    e.chkAll = all; e.chkState = st; e.chkIcount = ic;
    e.o = oA; e.o.icount = cntA;
    qA.push_back(e);
    e.o = oB; e.o.icount = {28'd0, cntB};
    qB.push_back(e);
  endfunction

  task automatic cmpField(input string who, input string name, input logic [31:0] act,
                          input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s.%s actual=%0h required=%0h at %0t", who, name, act, req, $time);
    end
  endtask

  task automatic checkOutput(input string who, input obs_t act, input exp_t e);
    if (e.chkState) cmpField(who, "state", 32'(act.state), 32'(e.o.state));
    cmpField(who, "pc_write",  32'(act.pcWrite),  32'(e.o.pcWrite));
    cmpField(who, "ir_write",  32'(act.irWrite),  32'(e.o.irWrite));
    cmpField(who, "reg_write", 32'(act.regWrite), 32'(e.o.regWrite));
    cmpField(who, "mem_read",  32'(act.memRead),  32'(e.o.memRead));
    cmpField(who, "mem_write", 32'(act.memWrite), 32'(e.o.memWrite));
    cmpField(who, "illegal",   32'(act.illegal),  32'(e.o.illegal));
    if (e.chkAll) begin
      cmpField(who, "pc_src",      32'(act.pcSrc),     32'(e.o.pcSrc));
      cmpField(who, "s_ext",       32'(act.sExt),      32'(e.o.sExt));
      cmpField(who, "s_num_write", 32'(act.sNumWrite), 32'(e.o.sNumWrite));
      cmpField(who, "s_b",         32'(act.sB),        32'(e.o.sB));
      cmpField(who, "s_wb",        32'(act.sWb),       32'(e.o.sWb));
      cmpField(who, "aluop",       32'(act.aluop),     32'(e.o.aluop));
    end
    if (e.chkIcount) cmpField(who, "icount", act.icount, e.o.icount);
  endtask

  // Monitor: one expectation per DUT per cycle, sampled mid-cycle.
  always @(negedge clock) begin
    if (qA.size() > 0) begin
      eA = qA.pop_front();
      checkOutput("trap32", obsA, eA);
    end
    if (qB.size() > 0) begin
      eB = qB.pop_front();
      checkOutput("notrap4", obsB, eB);
    end
  end

  task automatic resetCycle(input bit knownState);
    obs_t o;
    @(posedge clock); #1;
    reset = 1'b1;
    o = '0;
    pushExp(o, o, 1'b0, knownState, 1'b1);
  endtask

  task automatic applyReset(input int n);
    resetCycle(1'b0);
    cntA = '0; cntB = '0;
    for (int i = 1; i < n; i++) resetCycle(1'b1);
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] funct,
                               input logic zero, input int abortAt);
    obs_t o;
    buildSteps(op, funct, zero);
    for (int i = 0; i < steps.size(); i++) begin
      @(posedge clock); #1;
      if (i == 0) begin
        opR = op; functR = funct; zeroR = zero;
      end
      if (i == abortAt) begin
        reset = 1'b1;
        o = '0; o.state = steps[i].state;
        pushExp(o, o, 1'b0, 1'b1, 1'b1);
        cntA = '0; cntB = '0;
        return;
      end
      reset = 1'b0;
      pushExp(steps[i], steps[i], 1'b1, 1'b1, 1'b1);
    end
    cntA = cntA + 32'd1;
    cntB = cntB + 4'd1;
  endtask

  // Trapping instance parks in HALT; the other keeps re-fetching the same illegal word.
  task automatic applyIllegal(input logic [5:0] op, input logic [5:0] funct, input int nHalt);
    obs_t a, b;
    @(posedge clock); #1;
    reset = 1'b0; opR = op; functR = funct; zeroR = 1'($urandom);
    a = '0; a.irWrite = 1'b1; a.pcWrite = 1'b1;
    pushExp(a, a, 1'b1, 1'b1, 1'b1);
    @(posedge clock); #1;
    a = '0; a.state = 3'd1;
    pushExp(a, a, 1'b1, 1'b1, 1'b1);
    for (int j = 0; j < nHalt; j++) begin
      @(posedge clock); #1;
      a = '0; a.state = 3'd5; a.illegal = 1'b1;
      b = '0;
      if (j % 2 == 0) begin
        b.irWrite = 1'b1; b.pcWrite = 1'b1;
      end else begin
        b.state = 3'd1;
      end
      pushExp(a, b, 1'b1, 1'b1, 1'b1);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [5:0] op, f;
    int r, abortAt;
    legalOp = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
    rFunct  = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A};

    applyReset(2);
    applyStimulus(6'h00, 6'h21, 1'b0, -1);
    applyStimulus(6'h23, 6'h15, 1'b0, -1);
    applyStimulus(6'h2B, 6'h00, 1'b1, -1);
    applyStimulus(6'h04, 6'h00, 1'b1, -1);
    applyStimulus(6'h04, 6'h00, 1'b0, -1);
    applyStimulus(6'h02, 6'h3F, 1'b0, -1);
    applyStimulus(6'h0F, 6'h00, 1'b0, -1);
    applyIllegal(6'h3F, 6'h00, 20);
    applyReset(2);
    applyStimulus(6'h00, 6'h21, 1'b0, 3);
    applyStimulus(6'h02, 6'h00, 1'b0, -1);
    applyReset(2);
    for (int n = 0; n < 20; n++) applyStimulus(6'h02, 6'($urandom), 1'b0, -1);

    for (int n = 0; n < 80; n++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        do begin
          op = 6'($urandom);
          f  = 6'($urandom);
        end while (kindOf(op, f) != K_ILL);
        applyIllegal(op, f, 2 * int'($urandom_range(1, 5)));
        applyReset(2);
      end else begin
        op = legalOp[$urandom_range(0, 9)];
        f  = (op == 6'h00) ? rFunct[$urandom_range(0, 4)] : 6'($urandom);
        abortAt = (r == 1) ? int'($urandom_range(0, 4)) : -1;
        applyStimulus(op, f, 1'($urandom), abortAt);
      end
    end

    @(posedge clock); #1;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    cmpField("tb", "qA_left", 32'(qA.size()), 32'd0);
    cmpField("tb", "qB_left", 32'(qB.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
